// File: rtl/grid_pkg.sv
// Shared register map, CONTROL bit positions and default geometry for the
// Tetris playfield MMIO bridge.
package grid_pkg;

   localparam int DEF_COLS = 10;
   localparam int DEF_ROWS = 20;

   // Register offsets relative to REG_BASE
   localparam int REG_STATUS  = 0;
   localparam int REG_CONTROL = 1;
   localparam int REG_DIRTY   = 2;

   // CONTROL bit indices
   localparam int CTRL_SNAP    = 0;
   localparam int CTRL_AUTO_EN = 1;
   localparam int CTRL_FREEZE  = 2;
   localparam int CTRL_IRQ_EN  = 3;

   typedef logic [DEF_COLS-1:0] row_t;

   function automatic logic [31:0] pack_status(input logic [15:0] frame_count,
                                               input logic        freeze,
                                               input logic        auto_pending,
                                               input logic        dirty_any);
      return {frame_count, 13'd0, freeze, auto_pending, dirty_any};
   endfunction

endpackage

// File: rtl/grid_snapshot.sv
// Snapshot register of the playfield, per-row change detection feeding a
// read-clearable dirty mask, and the 16-bit frame counter.
module grid_snapshot
   import grid_pkg::*;
#(
   parameter int COLS  = DEF_COLS,
   parameter int ROWS  = DEF_ROWS,
   parameter int SEL_W = 5
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 capture,
   input  logic                 dirty_clear,
   input  logic [COLS*ROWS-1:0] grid_state,
   input  logic [SEL_W-1:0]     row_sel,
   output logic [COLS-1:0]      row_data,
   output logic [ROWS-1:0]      dirty,
   output logic [15:0]          frame_count
);

   logic [COLS*ROWS-1:0] snap;
   logic [ROWS-1:0]      changed;

   // Row 0 lives in the MSBs of both the live grid and the snapshot.
   always_comb begin
      changed = '0;
      for (int r = 0; r < ROWS; r++) begin
         changed[r] = grid_state[(ROWS-1-r)*COLS +: COLS] != snap[(ROWS-1-r)*COLS +: COLS];
      end
   end

   always_comb begin
      row_data = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (row_sel == SEL_W'(r)) row_data = snap[(ROWS-1-r)*COLS +: COLS];
      end
   end

   // A clearing read and a capture on the same edge keep the capture's bits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         snap        <= '0;
         dirty       <= '0;
         frame_count <= '0;
      end else begin
         dirty <= (dirty_clear ? '0 : dirty) | (capture ? changed : '0);
         if (capture) begin
            snap        <= grid_state;
            frame_count <= frame_count + 16'd1;
         end
      end
   end

endmodule

// File: rtl/grid_mmio_bridge.sv
// Avalon-MM slave exposing a coherent snapshot of the playfield: address
// decode, CONTROL register, deferred auto-capture flag and read pipeline.
module grid_mmio_bridge
   import grid_pkg::*;
#(
   parameter int COLS   = DEF_COLS,
   parameter int ROWS   = DEF_ROWS,
   parameter int ADDR_W = 6
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [COLS*ROWS-1:0] grid_state,
   input  logic                 grid_update,
   input  logic                 avs_read,
   input  logic                 avs_write,
   input  logic [ADDR_W-1:0]    avs_address,
   input  logic [31:0]          avs_writedata,
   output logic [31:0]          avs_readdata,
   output logic                 avs_readdatavalid,
   output logic                 irq
);

   localparam int REG_BASE = 1 << (ADDR_W - 1);
   localparam int SEL_W    = (ADDR_W > 1) ? ADDR_W - 1 : 1;

   localparam logic [ADDR_W-1:0] ADDR_STATUS  = ADDR_W'(REG_BASE + REG_STATUS);
   localparam logic [ADDR_W-1:0] ADDR_CONTROL = ADDR_W'(REG_BASE + REG_CONTROL);
   localparam logic [ADDR_W-1:0] ADDR_DIRTY   = ADDR_W'(REG_BASE + REG_DIRTY);

   // Handshake: no waitrequest; every avs_read sampled on an edge returns
   // exactly one avs_readdatavalid pulse in the following cycle, carrying
   // pre-edge state. avs_readdata holds its last value between reads.

   logic            auto_en, freeze, irq_en, auto_pending;
   logic            wr_ctrl, snap_wr, capture, dirty_clear, is_row;
   logic [31:0]     rd_word;
   logic [COLS-1:0] row_data;
   logic [ROWS-1:0] dirty;
   logic [15:0]     frame_count;
   logic            unused_wdata;

   assign unused_wdata = ^avs_writedata[31:4];

   assign wr_ctrl     = avs_write && (avs_address == ADDR_CONTROL);
   assign snap_wr     = wr_ctrl && avs_writedata[CTRL_SNAP];
   assign capture     = snap_wr || ((grid_update || auto_pending) && auto_en && !freeze);
   assign dirty_clear = avs_read && (avs_address == ADDR_DIRTY);
   assign is_row      = {{(32-ADDR_W){1'b0}}, avs_address} < 32'(ROWS);

   grid_snapshot #(
      .COLS  (COLS),
      .ROWS  (ROWS),
      .SEL_W (SEL_W)
   ) u_snapshot (
      .clk         (clk),
      .reset_n     (reset_n),
      .capture     (capture),
      .dirty_clear (dirty_clear),
      .grid_state  (grid_state),
      .row_sel     (avs_address[SEL_W-1:0]),
      .row_data    (row_data),
      .dirty       (dirty),
      .frame_count (frame_count)
   );

   always_comb begin
      rd_word = '0;
      if (is_row) begin
         rd_word = 32'(row_data);
      end else begin
         case (avs_address)
            ADDR_STATUS:  rd_word = pack_status(frame_count, freeze, auto_pending, |dirty);
            ADDR_CONTROL: rd_word = {28'd0, irq_en, freeze, auto_en, 1'b0};
            ADDR_DIRTY:   rd_word = 32'(dirty);
            default:      rd_word = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         auto_en           <= 1'b0;
         freeze            <= 1'b0;
         irq_en            <= 1'b0;
         auto_pending      <= 1'b0;
         avs_readdata      <= '0;
         avs_readdatavalid <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            auto_en <= avs_writedata[CTRL_AUTO_EN];
            freeze  <= avs_writedata[CTRL_FREEZE];
            irq_en  <= avs_writedata[CTRL_IRQ_EN];
         end
         // Disabling auto mode drops a deferred capture; a capture consumes it.
         if (wr_ctrl && !avs_writedata[CTRL_AUTO_EN]) auto_pending <= 1'b0;
         else if (capture)                             auto_pending <= 1'b0;
         else if (grid_update && auto_en && freeze)    auto_pending <= 1'b1;

         avs_readdatavalid <= avs_read;
         if (avs_read) avs_readdata <= rd_word;
      end
   end

   assign irq = irq_en && (|dirty);

endmodule

// File: tb/tb_grid_mmio_bridge.sv
// Scoreboard bench for grid_mmio_bridge: read expectations are queued when a
// read is issued and checked when avs_readdatavalid returns.
module tb_grid_mmio_bridge;
   import grid_pkg::*;

   localparam int COLS   = 10;
   localparam int ROWS   = 20;
   localparam int ADDR_W = 6;
   localparam logic [5:0] A_STATUS = 6'd32;
   localparam logic [5:0] A_CTRL   = 6'd33;
   localparam logic [5:0] A_DIRTY  = 6'd34;

   logic                 clk;
   logic                 reset_n;
   logic [COLS*ROWS-1:0] grid_state;
   logic                 grid_update;
   logic                 avs_read;
   logic                 avs_write;
   logic [ADDR_W-1:0]    avs_address;
   logic [31:0]          avs_writedata;
   logic [31:0]          avs_readdata;
   logic                 avs_readdatavalid;
   logic                 irq;

   logic [31:0] exp_q[$];
   logic [5:0]  addr_q[$];
   int          checks;
   int          errors;
   row_t        model_rows[ROWS];

   grid_mmio_bridge #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .grid_state        (grid_state),
      .grid_update       (grid_update),
      .avs_read          (avs_read),
      .avs_write         (avs_write),
      .avs_address       (avs_address),
      .avs_writedata     (avs_writedata),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .irq               (irq)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard monitor
   always @(negedge clk) begin
      if (avs_readdatavalid) begin
         logic [31:0] e;
         logic [5:0]  a;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: got data %h, required no valid", avs_readdata);
         end else begin
            e = exp_q.pop_front();
            a = addr_q.pop_front();
            if (avs_readdata !== e) begin
               errors++;
               $display("FAIL read_addr_%0d: got %h, required %h", a, avs_readdata, e);
            end
         end
      end
   end

   // driver tasks
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_row(input int r, input logic [COLS-1:0] v);
      grid_state[(ROWS-1-r)*COLS +: COLS] = v;
   endtask

   task automatic rd(input logic [5:0] a, input logic [31:0] e);
      avs_read    = 1'b1;
      avs_address = a;
      exp_q.push_back(e);
      addr_q.push_back(a);
      @(negedge clk);
      avs_read = 1'b0;
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      avs_write     = 1'b1;
      avs_address   = a;
      avs_writedata = d;
      @(negedge clk);
      avs_write = 1'b0;
   endtask

   task automatic test_reset();
      avs_read    = 1'b1;
      avs_address = 6'd0;
      #2 reset_n = 1'b0;
      @(negedge clk);
      avs_read = 1'b0;
      checks++;
      if (avs_readdatavalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b, required 0", avs_readdatavalid);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq: got %b, required 0", irq);
      end
      checks++;
      if (avs_readdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_readdata: got %h, required 0", avs_readdata);
      end
      reset_n = 1'b1;
      idle(1);
      for (int r = 0; r < ROWS; r++) rd(6'(r), 32'd0);
      rd(A_STATUS, 32'd0);
      idle(2);
   endtask

   task automatic test_manual_snap();
      set_row(0, 10'h3FF);
      set_row(19, 10'h001);
      wr(A_CTRL, 32'h1);
      avs_read    = 1'b1;
      avs_address = 6'd0;
      exp_q.push_back(32'h3FF);
      addr_q.push_back(6'd0);
      @(negedge clk);
      avs_read = 1'b0;
      checks++;
      if (avs_readdatavalid !== 1'b1) begin
         errors++;
         $display("FAIL snap_latency: got valid %b, required 1", avs_readdatavalid);
      end
      rd(6'd19, 32'h001);
      rd(A_STATUS, 32'h0001_0001);
      rd(A_CTRL, 32'h0);
      rd(A_DIRTY, 32'h8_0001);
      rd(A_DIRTY, 32'h0);
      idle(2);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL snap_irq_disabled: got %b, required 0", irq);
      end
   endtask

   task automatic test_auto_freeze();
      wr(A_CTRL, 32'h6);
      set_row(3, 10'h0AA);
      grid_update = 1'b1;
      @(negedge clk);
      grid_update = 1'b0;
      rd(A_STATUS, 32'h0001_0006);
      rd(6'd3, 32'h0);
      wr(A_CTRL, 32'h2);
      idle(1);
      rd(A_STATUS, 32'h0002_0001);
      rd(6'd3, 32'h0AA);
      rd(A_DIRTY, 32'h8);
      // pending dropped by clearing AUTO_EN
      wr(A_CTRL, 32'h6);
      grid_update = 1'b1;
      @(negedge clk);
      grid_update = 1'b0;
      rd(A_STATUS, 32'h0002_0006);
      wr(A_CTRL, 32'h0);
      rd(A_STATUS, 32'h0002_0000);
      idle(2);
   endtask

   task automatic test_read_clear_race();
      set_row(2, 10'h155);
      wr(A_CTRL, 32'hB);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL race_irq_rise: got %b, required 1", irq);
      end
      set_row(5, 10'h03C);
      avs_read    = 1'b1;
      avs_address = A_DIRTY;
      grid_update = 1'b1;
      exp_q.push_back(32'h4);
      addr_q.push_back(A_DIRTY);
      @(negedge clk);
      avs_read    = 1'b0;
      grid_update = 1'b0;
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL race_irq_hold: got %b, required 1", irq);
      end
      wr(A_CTRL, 32'h0);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL race_irq_fall: got %b, required 0", irq);
      end
      rd(A_DIRTY, 32'h20);
      rd(A_STATUS, 32'h0004_0000);
      idle(2);
   endtask

   task automatic test_out_of_range_wrap();
      rd(6'd20, 32'h0);
      rd(6'd31, 32'h0);
      rd(6'd35, 32'h0);
      rd(6'd63, 32'h0);
      wr(6'd35, 32'hF);
      rd(A_CTRL, 32'h0);
      rd(A_STATUS, 32'h0004_0000);
      avs_write     = 1'b1;
      avs_address   = A_CTRL;
      avs_writedata = 32'h1;
      repeat (65531) @(negedge clk);
      avs_write = 1'b0;
      rd(A_STATUS, 32'hFFFF_0000);
      wr(A_CTRL, 32'h1);
      rd(A_STATUS, 32'h0000_0000);
      idle(2);
   endtask

   task automatic test_back_to_back();
      int valid_cycles;
      for (int r = 0; r < ROWS; r++) begin
         model_rows[r] = row_t'($urandom_range(0, 1023));
         set_row(r, model_rows[r]);
      end
      wr(A_CTRL, 32'h1);
      valid_cycles = 0;
      for (int r = 0; r < ROWS; r++) begin
         avs_read    = 1'b1;
         avs_address = 6'(r);
         exp_q.push_back(32'(model_rows[r]));
         addr_q.push_back(6'(r));
         @(negedge clk);
         if (avs_readdatavalid === 1'b1) valid_cycles++;
      end
      avs_read = 1'b0;
      checks++;
      if (valid_cycles !== ROWS) begin
         errors++;
         $display("FAIL b2b_valid_cycles: got %0d, required %0d", valid_cycles, ROWS);
      end
      idle(1);
      checks++;
      if (avs_readdatavalid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_valid_drop: got %b, required 0", avs_readdatavalid);
      end
      idle(2);
   endtask

   initial begin
      reset_n       = 1'b0;
      grid_state    = '0;
      grid_update   = 1'b0;
      avs_read      = 1'b0;
      avs_write     = 1'b0;
      avs_address   = '0;
      avs_writedata = '0;
      checks        = 0;
      errors        = 0;
      idle(3);
      reset_n = 1'b1;
      idle(2);
      test_reset();
      test_manual_snap();
      test_auto_freeze();
      test_read_clear_race();
      test_out_of_range_wrap();
      test_back_to_back();
      idle(3);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_queue: got %0d outstanding, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/grid_mmio_bridge.md
# grid_mmio_bridge

Parametrised Avalon-MM slave exposing the Tetris playfield to the soft CPU. Holds a coherent snapshot of the live `grid_state` vector and serves any row by address with a registered, `readdatavalid`-qualified read. Snapshots are taken on CPU command or automatically on the game engine's `grid_update` pulse. Per-row dirty tracking and an interrupt let software redraw only changed rows. Sits between the game-logic grid register and the Avalon interconnect.

## Interface
- `COLS`, 10, cells per row; 1..32
- `ROWS`, 20, rows in the grid; 1..32 and ≤ 2^(ADDR_W-1)
- `ADDR_W`, 6, word address width; register base is `REG_BASE` = 2^(ADDR_W-1)
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `grid_state`  in  COLS*ROWS  live grid; row r = `grid_state[(ROWS-1-r)*COLS +: COLS]`, row 0 in the MSBs
- `grid_update`  in  1  one-cycle pulse from game logic when the grid changed
- `avs_read`  in  1  read strobe
- `avs_write`  in  1  write strobe
- `avs_address`  in  ADDR_W  word address
- `avs_writedata`  in  32  write data
- `avs_readdata`  out  32  read data
- `avs_readdatavalid`  out  1  qualifies `avs_readdata`
- `irq`  out  1  level interrupt

## Operation
- **Address map:**
  - 0..ROWS-1: snapshot row, zero-extended (`COLS` LSBs).
  - ROWS..REG_BASE-1: read 0.
  - REG_BASE+0, STATUS (RO):
    - bit0 = |dirty
    - bit1 = auto_pending
    - bit2 = freeze
    - [31:16] = frame_count
  - REG_BASE+1, CONTROL (RW):
    - bit0 SNAP: write-1 pulse, reads 0
    - bit1 AUTO_EN
    - bit2 FREEZE
    - bit3 IRQ_EN
    - other bits read 0
  - REG_BASE+2, DIRTY (RO, read-clear): bit r = row r changed since last DIRTY read.
  - All other addresses read 0; writes to them are ignored.
- **Capture:** occurs on an edge when any of the following holds:
  - SNAP is written as 1, or
  - `grid_update` & AUTO_EN & !FREEZE, or
  - auto_pending & AUTO_EN & !FREEZE.
- **On capture:**
  - snapshot <= `grid_state`.
  - dirty[r] |= (`grid_state` row r != snapshot row r).
  - frame_count += 1, 16-bit wrap.
  - auto_pending cleared.
- **Simultaneous triggers:** multiple capture triggers on the same edge produce exactly one capture and one count.
- **Freeze:** `grid_update` with AUTO_EN & FREEZE sets auto_pending instead of capturing. SNAP still captures while frozen.
- **Pending cleanup:** writing AUTO_EN=0 clears auto_pending.
- **DIRTY read vs. capture on the same edge:**
  - The read returns the pre-edge mask.
  - dirty_next = new capture bits only; bits set by that capture are not lost.
- **Interrupt:** `irq` = IRQ_EN & |dirty, driven from registers only.
- **Reset values:**
  - snapshot, dirty, frame_count, CONTROL and auto_pending all 0.
  - `avs_readdata` = 0, `avs_readdatavalid` = 0, `irq` = 0.

## Timing
- **Read latency:** fixed 1 cycle. `avs_read` at edge N gives `avs_readdata` and `avs_readdatavalid`=1 during the cycle after edge N.
- **`avs_readdatavalid` between reads:** 1 cycle per read; 0 otherwise. Back-to-back reads are supported every cycle.
- **`avs_readdata` between reads:** holds its last value when no read is issued.
- **No waitrequest:** the slave never stalls.
- **Read vs. capture on the same edge:** a row read returns the pre-capture snapshot. STATUS returns the pre-capture count.
- **Read vs. write on the same edge:** both are serviced; the read returns the pre-write value.
- **Write timing:** takes effect at the sampling edge. SNAP capture occurs at that same edge.
- **`irq` timing:** rises in the cycle after the capture edge that first sets dirty. Falls in the cycle after a DIRTY read edge, or after a write of IRQ_EN=0, provided no new bits are set on that edge.
- **Mid-operation reset:** `reset_n` low asserts asynchronously. An in-flight read produces no `avs_readdatavalid`.

## Structure
- **Package `grid_pkg`:**
  - Register offsets `REG_STATUS`=0, `REG_CONTROL`=1, `REG_DIRTY`=2 (relative to `REG_BASE`).
  - CONTROL bit indices.
  - Default `COLS`/`ROWS`.
  - A `row_t` typedef sized by `COLS`.
- **Sub-module `grid_snapshot`:** snapshot register array, per-row compare, dirty mask with read-clear port, frame counter.
- **Top level:** address decode, CONTROL register, auto_pending flag and the read pipeline.

## Test plan
- **Reset:** assert `reset_n`=0 mid-read → `avs_readdatavalid`=0, `irq`=0, reads of rows 0..19 return 0, STATUS returns 0.
- **Manual snap:**
  - Stimulus: row 0 = 10'h3FF, row 19 = 10'h001; write CONTROL=0x1; read addr 0 and 19.
  - Required: 32'h3FF and 32'h001, each 1 cycle after its read.
  - DIRTY read returns 0x80001; a second DIRTY read returns 0.
- **Auto/freeze:**
  - Stimulus: CONTROL=0x6 (AUTO_EN, FREEZE); pulse `grid_update` → no capture, STATUS bit1=1.
  - Then write CONTROL=0x2 → capture next edge, frame_count=1, pending cleared.
- **Read-clear race:**
  - Stimulus: IRQ_EN set, dirty=0x4; DIRTY read and a capture changing row 5 on the same edge.
  - Required: read returns 0x4, DIRTY afterwards = 0x20, `irq` stays 1.
- **Out-of-range and counter wrap:**
  - Reads of addr 20, 31 and REG_BASE+3 return 0 with valid.
  - 65536 SNAP writes return frame_count to 0.
- **Throughput:** 20 back-to-back row reads → 20 consecutive valid cycles with correct per-row data.
